// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer slice.
//   ROB_DISPATCH_PACKET : rename/dispatch -> ROB (dis_valid, tag, tag_old)
//   CDB_PACKET          : completion broadcast (cdb_valid, tag, mispredict)
//   RETIRE_ROB_PACKET   : ROB -> arch map table / free list (ret_valid, tag, tag_old)
package reorder_buffer_pkg;

  // Physical register tag width.
  localparam int unsigned CDB_BITS     = 6;
  // Default dispatch / CDB / retire width.
  localparam int unsigned DEF_N_WAY    = 3;
  // Default entry count; must be a power of two.
  localparam int unsigned DEF_ROB_SIZE = 32;
  localparam int unsigned ROB_IDX_BITS = $clog2(DEF_ROB_SIZE);

  typedef struct packed {
    logic                dis_valid;
    logic [CDB_BITS-1:0] tag;
    logic [CDB_BITS-1:0] tag_old;
  } ROB_DISPATCH_PACKET;

  typedef struct packed {
    logic                cdb_valid;
    logic [CDB_BITS-1:0] tag;
    logic                mispredict;
  } CDB_PACKET;

  typedef struct packed {
    logic                ret_valid;
    logic [CDB_BITS-1:0] tag;
    logic [CDB_BITS-1:0] tag_old;
  } RETIRE_ROB_PACKET;

endpackage

// File: rtl/rob_retire_select.sv
// Retire selection for the reorder buffer. Purely combinational.
// Ports:
//   valid_i, complete_i, mispredict_i : per-way state of the N_WAY entries starting at head
//   ret_en_o : way k retires (entries 0..k valid+complete, none of 0..k-1 mispredicted)
//   n_ret_o  : number of retiring ways
//   flush_o  : a retiring entry is mispredicted
module rob_retire_select #(
  parameter int unsigned N_WAY = 3
) (
  input  logic [N_WAY-1:0]               valid_i,
  input  logic [N_WAY-1:0]               complete_i,
  input  logic [N_WAY-1:0]               mispredict_i,
  output logic [N_WAY-1:0]               ret_en_o,
  output logic [$clog2(N_WAY+1)-1:0]     n_ret_o,
  output logic                           flush_o
);

  localparam int unsigned WayW = $clog2(N_WAY + 1);

  logic chain;

  always_comb begin
    chain    = 1'b1;
    ret_en_o = '0;
    n_ret_o  = '0;
    flush_o  = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      chain       = chain & valid_i[k] & complete_i[k];
      ret_en_o[k] = chain;
      n_ret_o     = n_ret_o + WayW'(chain);
      flush_o     = flush_o | (chain & mispredict_i[k]);
      // A mispredicted entry is the last one allowed to retire this cycle.
      chain       = chain & ~mispredict_i[k];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between rename/dispatch and retirement.
// Ports:
//   clock, reset : clock; synchronous active-high reset
//   dis_packet   : up to N_WAY renamed instructions, compacted into consecutive slots at tail
//   cdb_packet   : completion broadcasts; mark matching entries complete (and mispredicted)
//   ret_packet   : up to N_WAY oldest complete entries retiring this cycle
//   free_slots   : unoccupied entries, from registered count
//   flush        : a mispredicted entry retires this cycle; the whole window clears at the edge
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = DEF_ROB_SIZE,
  parameter int unsigned N_WAY    = DEF_N_WAY
) (
  input  logic                               clock,
  input  logic                               reset,
  input  ROB_DISPATCH_PACKET [N_WAY-1:0]     dis_packet,
  input  CDB_PACKET          [N_WAY-1:0]     cdb_packet,
  output RETIRE_ROB_PACKET   [N_WAY-1:0]     ret_packet,
  output logic [$clog2(ROB_SIZE+1)-1:0]      free_slots,
  output logic                               flush
);

  localparam int unsigned IdxW = $clog2(ROB_SIZE);
  localparam int unsigned CntW = $clog2(ROB_SIZE + 1);
  localparam int unsigned WayW = $clog2(N_WAY + 1);

  // Entry state
  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] complete_q, complete_d;
  logic [ROB_SIZE-1:0] misp_q, misp_d;
  logic [CDB_BITS-1:0] tag_q     [ROB_SIZE];
  logic [CDB_BITS-1:0] tag_d     [ROB_SIZE];
  logic [CDB_BITS-1:0] tag_old_q [ROB_SIZE];
  logic [CDB_BITS-1:0] tag_old_d [ROB_SIZE];

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Retire window
  logic [IdxW-1:0]  win_idx [N_WAY];
  logic [N_WAY-1:0] win_valid, win_complete, win_misp;
  logic [N_WAY-1:0] ret_en;
  logic [WayW-1:0]  n_ret;

  // Dispatch
  logic [IdxW-1:0]  dis_idx [N_WAY];
  logic [N_WAY-1:0] dis_hit, dis_misp;
  logic [WayW-1:0]  n_dis;

  always_comb begin
    for (int k = 0; k < N_WAY; k++) begin
      win_idx[k]      = head_q + IdxW'(k);
      win_valid[k]    = valid_q[win_idx[k]];
      win_complete[k] = complete_q[win_idx[k]];
      win_misp[k]     = misp_q[win_idx[k]];
    end
  end

  rob_retire_select #(
    .N_WAY (N_WAY)
  ) u_retire_select (
    .valid_i      (win_valid),
    .complete_i   (win_complete),
    .mispredict_i (win_misp),
    .ret_en_o     (ret_en),
    .n_ret_o      (n_ret),
    .flush_o      (flush)
  );

  always_comb begin
    for (int k = 0; k < N_WAY; k++) begin
      ret_packet[k].ret_valid = ret_en[k];
      ret_packet[k].tag       = ret_en[k] ? tag_q[win_idx[k]]     : '0;
      ret_packet[k].tag_old   = ret_en[k] ? tag_old_q[win_idx[k]] : '0;
    end
  end

  assign free_slots = CntW'(ROB_SIZE) - count_q;

  // Compact valid ways into consecutive slots. The CDB cannot see an entry that is
  // only being written this cycle, so match dispatch tags against the CDB directly.
  always_comb begin
    n_dis = '0;
    for (int i = 0; i < N_WAY; i++) begin
      dis_idx[i]  = tail_q + IdxW'(n_dis);
      dis_hit[i]  = 1'b0;
      dis_misp[i] = 1'b0;
      for (int w = 0; w < N_WAY; w++) begin
        if (cdb_packet[w].cdb_valid && (cdb_packet[w].tag == dis_packet[i].tag)) begin
          dis_hit[i]  = 1'b1;
          dis_misp[i] = dis_misp[i] | cdb_packet[w].mispredict;
        end
      end
      n_dis = n_dis + WayW'(dis_packet[i].dis_valid);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    misp_d     = misp_q;
    tag_d      = tag_q;
    tag_old_d  = tag_old_q;
    head_d     = head_q + IdxW'(n_ret);
    tail_d     = tail_q + IdxW'(n_dis);
    count_d    = count_q + CntW'(n_dis) - CntW'(n_ret);

    for (int e = 0; e < ROB_SIZE; e++) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (cdb_packet[w].cdb_valid && valid_q[e] && (tag_q[e] == cdb_packet[w].tag)) begin
          complete_d[e] = 1'b1;
          if (cdb_packet[w].mispredict) begin
            misp_d[e] = 1'b1;
          end
        end
      end
    end

    for (int k = 0; k < N_WAY; k++) begin
      if (ret_en[k]) begin
        valid_d[win_idx[k]]    = 1'b0;
        complete_d[win_idx[k]] = 1'b0;
        misp_d[win_idx[k]]     = 1'b0;
      end
    end

    // Upstream never dispatches past free_slots, so these slots are never retiring.
    for (int i = 0; i < N_WAY; i++) begin
      if (dis_packet[i].dis_valid) begin
        valid_d[dis_idx[i]]    = 1'b1;
        complete_d[dis_idx[i]] = dis_hit[i];
        misp_d[dis_idx[i]]     = dis_misp[i];
        tag_d[dis_idx[i]]      = dis_packet[i].tag;
        tag_old_d[dis_idx[i]]  = dis_packet[i].tag_old;
      end
    end

    // Flush discards everything younger than the retiring branch, including this
    // cycle's dispatch and CDB updates.
    if (flush) begin
      valid_d    = '0;
      complete_d = '0;
      misp_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      misp_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      misp_q     <= misp_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Tag payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clock) begin
    tag_q     <= tag_d;
    tag_old_q <= tag_old_d;
  end

  dis_fits_free: assert property (@(posedge clock) disable iff (reset)
    (CntW'(n_dis) <= free_slots));

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int unsigned NW = 3;
  localparam int unsigned RS = 8;

  logic clock = 1'b0;
  logic reset;
  ROB_DISPATCH_PACKET [NW-1:0] dis_packet;
  CDB_PACKET          [NW-1:0] cdb_packet;
  RETIRE_ROB_PACKET   [NW-1:0] ret_packet;
  logic [3:0]                  free_slots;
  logic                        flush;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer #(
    .ROB_SIZE (RS),
    .N_WAY    (NW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dis_packet (dis_packet),
    .cdb_packet (cdb_packet),
    .ret_packet (ret_packet),
    .free_slots (free_slots),
    .flush      (flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the ROB is an ordered queue, oldest first.
  typedef struct {
    logic [5:0] tag;
    logic [5:0] tag_old;
    bit         done;
    bit         misp;
  } ent_t;

  ent_t rob_q[$];
  bit   model_on = 1'b0;
  int   m_nret;
  bit   m_flush;
  bit   m_chain;
  bit   m_rv;
  ent_t m_new;

  always @(negedge clock) begin
    m_nret  = 0;
    m_flush = 1'b0;
    if (model_on) begin
      chk("free_slots", free_slots, RS - rob_q.size());
      m_chain = 1'b1;
      for (int k = 0; k < NW; k++) begin
        m_rv = m_chain && (k < rob_q.size()) && rob_q[k].done;
        chk($sformatf("ret_valid[%0d]", k), ret_packet[k].ret_valid, m_rv);
        chk($sformatf("ret_tag[%0d]", k), ret_packet[k].tag, m_rv ? rob_q[k].tag : 0);
        chk($sformatf("ret_tag_old[%0d]", k), ret_packet[k].tag_old,
            m_rv ? rob_q[k].tag_old : 0);
        if (m_rv) begin
          m_nret++;
          if (rob_q[k].misp) begin
            m_flush = 1'b1;
            m_chain = 1'b0;
          end
        end else begin
          m_chain = 1'b0;
        end
      end
      chk("flush", flush, m_flush);
    end
    if (reset) begin
      rob_q.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      if (m_flush) begin
        rob_q.delete();
      end else begin
        for (int w = 0; w < NW; w++) begin
          if (cdb_packet[w].cdb_valid) begin
            for (int j = 0; j < rob_q.size(); j++) begin
              if (rob_q[j].tag == cdb_packet[w].tag) begin
                rob_q[j].done = 1'b1;
                if (cdb_packet[w].mispredict) rob_q[j].misp = 1'b1;
              end
            end
          end
        end
        repeat (m_nret) void'(rob_q.pop_front());
        for (int i = 0; i < NW; i++) begin
          if (dis_packet[i].dis_valid) begin
            m_new.tag     = dis_packet[i].tag;
            m_new.tag_old = dis_packet[i].tag_old;
            m_new.done    = 1'b0;
            m_new.misp    = 1'b0;
            for (int w = 0; w < NW; w++) begin
              if (cdb_packet[w].cdb_valid && cdb_packet[w].tag == dis_packet[i].tag) begin
                m_new.done = 1'b1;
                if (cdb_packet[w].mispredict) m_new.misp = 1'b1;
              end
            end
            rob_q.push_back(m_new);
          end
        end
      end
    end
  end

  task automatic idle();
    dis_packet = '0;
    cdb_packet = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dis(input int w, input logic [5:0] t, input logic [5:0] o);
    dis_packet[w].dis_valid = 1'b1;
    dis_packet[w].tag       = t;
    dis_packet[w].tag_old   = o;
  endtask

  task automatic set_cdb(input int w, input logic [5:0] t, input bit m);
    cdb_packet[w].cdb_valid  = 1'b1;
    cdb_packet[w].tag        = t;
    cdb_packet[w].mispredict = m;
  endtask

  task automatic chk_ret(input string name, input int k, input int t, input int o);
    chk({name, "_valid"}, ret_packet[k].ret_valid, 1);
    chk({name, "_tag"}, ret_packet[k].tag, t);
    chk({name, "_tag_old"}, ret_packet[k].tag_old, o);
  endtask

  task automatic run_random(input int cycles);
    logic [5:0] tag_ctr;
    logic [5:0] new_tags [NW];
    logic [5:0] t;
    int nd, nfree, placed, pick;
    tag_ctr = 6'd4;
    for (int c = 0; c < cycles; c++) begin
      idle();
      reset  = ($urandom_range(0, 99) == 0);
      nfree  = RS - rob_q.size();
      nd     = $urandom_range(0, NW);
      if (nd > nfree) nd = nfree;
      placed = 0;
      for (int w = 0; w < NW; w++) begin
        if (placed < nd && ($urandom_range(0, 1) == 1 || (NW - w) == (nd - placed))) begin
          set_dis(w, tag_ctr, 6'($urandom_range(0, 63)));
          new_tags[placed] = tag_ctr;
          tag_ctr++;
          placed++;
        end else begin
          dis_packet[w].tag = 6'($urandom_range(0, 63));
        end
      end
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 2) != 0) begin
          pick = $urandom_range(0, rob_q.size() + nd);
          if (pick < rob_q.size()) t = rob_q[pick].tag;
          else if (pick < rob_q.size() + nd) t = new_tags[pick - rob_q.size()];
          else t = tag_ctr + 6'd32;
          set_cdb(w, t, $urandom_range(0, 9) == 0);
        end
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_free", free_slots, 8);
    chk("rst_flush", flush, 0);
    for (int k = 0; k < NW; k++) chk("rst_ret_valid", ret_packet[k].ret_valid, 0);

    // In-order retirement
    set_dis(0, 6'd33, 6'd1);
    set_dis(1, 6'd34, 6'd2);
    set_dis(2, 6'd35, 6'd3);
    tick();
    idle();
    set_cdb(0, 6'd35, 1'b0);
    chk("io_free_after_dis", free_slots, 5);
    tick();
    idle();
    set_cdb(1, 6'd34, 1'b0);
    chk("io_no_ret_35", ret_packet[0].ret_valid, 0);
    tick();
    idle();
    set_cdb(2, 6'd33, 1'b0);
    chk("io_no_ret_34", ret_packet[0].ret_valid, 0);
    tick();
    idle();
    chk_ret("io_w0", 0, 33, 1);
    chk_ret("io_w1", 1, 34, 2);
    chk_ret("io_w2", 2, 35, 3);
    tick();
    chk("io_free_back", free_slots, 8);

    // Gapped dispatch: ways 0 and 2
    set_dis(0, 6'd36, 6'd4);
    dis_packet[1].tag = 6'd63;
    set_dis(2, 6'd37, 6'd5);
    tick();
    idle();
    chk("gap_free", free_slots, 6);
    set_cdb(0, 6'd37, 1'b0);
    set_cdb(1, 6'd36, 1'b0);
    tick();
    idle();
    chk_ret("gap_w0", 0, 36, 4);
    chk_ret("gap_w1", 1, 37, 5);
    chk("gap_w2_idle", ret_packet[2].ret_valid, 0);
    tick();
    chk("gap_free_back", free_slots, 8);

    // Mispredict flush
    set_dis(0, 6'd40, 6'd7);
    set_dis(1, 6'd41, 6'd8);
    set_dis(2, 6'd42, 6'd9);
    tick();
    idle();
    set_cdb(0, 6'd40, 1'b1);
    set_cdb(1, 6'd41, 1'b0);
    tick();
    idle();
    chk_ret("fl_w0", 0, 40, 7);
    chk("fl_w1_blocked", ret_packet[1].ret_valid, 0);
    chk("fl_flush", flush, 1);
    set_dis(0, 6'd43, 6'd10);
    set_cdb(0, 6'd42, 1'b0);
    tick();
    idle();
    chk("fl_free", free_slots, 8);
    chk("fl_flush_off", flush, 0);
    chk("fl_no_41", ret_packet[0].ret_valid, 0);
    tick();
    chk("fl_still_empty", ret_packet[0].ret_valid, 0);

    // Full and wrap-around, with dispatch/retire overlap
    set_dis(0, 6'd50, 6'd20); set_dis(1, 6'd51, 6'd21); set_dis(2, 6'd52, 6'd22);
    tick();
    idle();
    set_dis(0, 6'd53, 6'd23); set_dis(1, 6'd54, 6'd24); set_dis(2, 6'd55, 6'd25);
    tick();
    idle();
    set_dis(0, 6'd56, 6'd26); set_dis(1, 6'd57, 6'd27);
    tick();
    idle();
    chk("full_free", free_slots, 0);
    set_cdb(0, 6'd50, 1'b0); set_cdb(1, 6'd51, 1'b0); set_cdb(2, 6'd52, 1'b0);
    tick();
    idle();
    chk("ovl_free_zero", free_slots, 0);
    chk_ret("ovl_w0", 0, 50, 20);
    chk_ret("ovl_w2", 2, 52, 22);
    set_cdb(0, 6'd53, 1'b0); set_cdb(1, 6'd54, 1'b0); set_cdb(2, 6'd55, 1'b0);
    tick();
    idle();
    chk("ovl_free_three", free_slots, 3);
    chk_ret("wr_w0", 0, 53, 23);
    set_dis(0, 6'd60, 6'd30); set_dis(1, 6'd61, 6'd31); set_dis(2, 6'd62, 6'd32);
    set_cdb(0, 6'd56, 1'b0); set_cdb(1, 6'd57, 1'b0);
    tick();
    idle();
    chk("wr_free", free_slots, 3);
    chk("wr_slot0", dut.tag_q[0], 60);
    chk("wr_slot1", dut.tag_q[1], 61);
    chk("wr_slot2", dut.tag_q[2], 62);
    chk_ret("wr_w1", 1, 57, 27);
    chk("wr_w2_incomplete", ret_packet[2].ret_valid, 0);
    set_cdb(0, 6'd62, 1'b0); set_cdb(1, 6'd60, 1'b0); set_cdb(2, 6'd61, 1'b0);
    tick();
    idle();
    chk("wr_free_mid", free_slots, 5);
    chk_ret("wr_new0", 0, 60, 30);
    chk_ret("wr_new2", 2, 62, 32);
    tick();
    chk("wr_free_back", free_slots, 8);

    // Reset mid-operation discards in-flight entries
    set_dis(0, 6'd1, 6'd11); set_dis(1, 6'd2, 6'd12); set_dis(2, 6'd3, 6'd13);
    tick();
    idle();
    reset = 1'b1;
    set_cdb(0, 6'd1, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    chk("mr_free", free_slots, 8);
    tick();
    chk("mr_no_ret", ret_packet[0].ret_valid, 0);

    // Randomized traffic against the queue model
    run_random(1500);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
